sdram_probe_seq: RTL and testbench

SDRAM_PROBE_SEQ -- requirements
Module: sdram_probe_seq

---
 rtl/sdram_probe_seq_pkg.sv | 60 ++++++
 rtl/sdram_probe_seq.sv | 113 +++++++++++
 tb/tb_sdram_probe_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_probe_seq_pkg.sv
// SDRAM size probe: shared types, probe step table and cfg layout.
// Step data doubles as the compare value for the reads.
package sdram_probe_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_GAP,
        PH_WAIT
    } phase_t;

    typedef struct packed {
        logic        wr;
        logic [26:0] addr;
        logic [15:0] data;
        logic [3:0]  bit_idx;
    } probe_step_t;

    localparam int PROBE_STEPS = 7;

    localparam int CFG_BANK0 = 0;
    localparam int CFG_BANK1 = 1;
    localparam int CFG_BANK2 = 2;
    localparam int CFG_DONE  = 15;

    function automatic probe_step_t probe_step(input logic [2:0] idx);
        probe_step_t s;
        s = '{wr: 1'b0, addr: '0, data: '0, bit_idx: '0};
        case (idx)
            3'd0: s = '{1'b1, 27'h4000000, 16'd3128, 4'd0};
            3'd1: s = '{1'b1, 27'h2000000, 16'd2064, 4'd0};
            3'd2: s = '{1'b1, 27'h0000000, 16'd1032, 4'd0};
            3'd3: s = '{1'b1, 27'h1000000, 16'd12345, 4'd0};
            3'd4: s = '{1'b0, 27'h4000000, 16'd3128, 4'(CFG_BANK2)};
            3'd5: s = '{1'b0, 27'h2000000, 16'd2064, 4'(CFG_BANK1)};
            3'd6: s = '{1'b0, 27'h0000000, 16'd1032, 4'(CFG_BANK0)};
            default: ;
        endcase
        return s;
    endfunction

    // Largest bank that read back correctly decides how far to clear.
    function automatic logic [26:0] clear_last(
        input logic b2,
        input logic b1,
        input logic b0
    );
        if (b2)      return 27'h7FFFFFF;
        else if (b1) return 27'h3FFFFFF;
        else if (b0) return 27'h1FFFFFF;
        else         return 27'h0FFFFFF;
    endfunction

endpackage

// File: rtl/sdram_probe_seq.sv
// SDRAM size probe: write/readback aliasing test, then paced zero-fill
// of the detected range. One command in flight at a time.
module sdram_probe_seq
    import sdram_probe_seq_pkg::*;
#(
    parameter int ADDR_W = 27,
    parameter int PACE   = 32
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    output logic [15:0]       cfg,
    output logic              busy,
    output logic              done
);

    state_t          state;
    phase_t          phase;
    logic [2:0]      step;
    logic [7:0]      pace_cnt;
    logic [ADDR_W:0] clr_addr;

    probe_step_t     cur;
    logic [26:0]     last_full;
    logic [ADDR_W:0] last_addr;
    logic            accept;
    logic            pace_ok;

    assign cur       = probe_step(step);
    assign last_full = clear_last(cfg[CFG_BANK2], cfg[CFG_BANK1],
                                  cfg[CFG_BANK0]);
    assign last_addr = {1'b0, last_full[ADDR_W-1:0]};
    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign pace_ok   = pace_cnt == 8'(PACE - 1);
    assign busy      = (state == ST_PROBE) || (state == ST_CLEAR);
    assign done      = state == ST_DONE;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            phase    <= PH_ISSUE;
            step     <= '0;
            pace_cnt <= '0;
            clr_addr <= '0;
            cfg      <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            mem_rd   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_rd <= 1'b0;
            if (state == ST_CLEAR && !pace_ok)
                pace_cnt <= pace_cnt + 8'd1;
            if (accept) begin
                state <= ST_PROBE;
                phase <= PH_ISSUE;
                step  <= '0;
                cfg   <= '0;
            end else if (state == ST_PROBE) begin
                unique case (phase)
                    PH_ISSUE: if (mem_ready) begin
                        mem_addr <= cur.addr[ADDR_W-1:0];
                        if (cur.wr) mem_din <= cur.data;
                        mem_we <= cur.wr;
                        mem_rd <= !cur.wr;
                        phase  <= PH_GAP;
                    end
                    PH_GAP: phase <= PH_WAIT;
                    PH_WAIT: if (mem_ready) begin
                        phase <= PH_ISSUE;
                        if (!cur.wr)
                            cfg[cur.bit_idx] <= mem_dout == cur.data;
                        if (step == 3'(PROBE_STEPS - 1)) begin
                            cfg[CFG_DONE] <= 1'b1;
                            state    <= ST_CLEAR;
                            clr_addr <= '0;
                            pace_cnt <= '0;
                        end else begin
                            step <= step + 3'd1;
                        end
                    end
                    default: phase <= PH_ISSUE;
                endcase
            end else if (state == ST_CLEAR) begin
                unique case (phase)
                    PH_ISSUE: if (mem_ready && pace_ok) begin
                        mem_addr <= clr_addr[ADDR_W-1:0];
                        mem_din  <= '0;
                        mem_we   <= 1'b1;
                        pace_cnt <= '0;
                        phase    <= PH_GAP;
                    end
                    PH_GAP: phase <= PH_WAIT;
                    PH_WAIT: if (mem_ready) begin
                        phase <= PH_ISSUE;
                        // extra counter bit keeps the compare from wrapping
                        if (clr_addr == last_addr) state <= ST_DONE;
                        else clr_addr <= clr_addr + 1'b1;
                    end
                    default: phase <= PH_ISSUE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_probe_seq.sv
// Bench for sdram_probe_seq: randomized SDRAM responder plus a
// cycle-level reference model compared against the DUT every cycle.
module tb_sdram_probe_seq;

    localparam int AW = 8;
    localparam int PC = 6;

    logic          clk_sys   = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic          mem_ready = 1'b1;
    logic [15:0]   mem_dout  = 16'd0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic          mem_we;
    logic          mem_rd;
    logic [15:0]   cfg;
    logic          busy;
    logic          done;

    always #5 clk_sys = ~clk_sys;

    sdram_probe_seq #(
        .ADDR_W(AW),
        .PACE  (PC)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .start    (start),
        .mem_ready(mem_ready),
        .mem_dout (mem_dout),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .cfg      (cfg),
        .busy     (busy),
        .done     (done)
    );

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    int          t_addr [7] = '{'h4000000, 'h2000000, 0, 'h1000000,
                                'h4000000, 'h2000000, 0};
    logic [15:0] t_data [7] = '{16'd3128, 16'd2064, 16'd1032, 16'd12345,
                                16'd3128, 16'd2064, 16'd1032};
    bit          t_wr   [7] = '{1, 1, 1, 1, 0, 0, 0};
    int          t_bit  [7] = '{0, 0, 0, 0, 2, 1, 0};

    // model: mode 0 idle, 1 probe, 2 clear, 3 done
    int            m_mode, m_k, m_iss, m_pace_at, m_ca;
    bit            m_out, m_we, m_rd;
    logic [15:0]   m_cfg, m_din;
    logic [AW-1:0] m_addr;

    // responder knobs
    int          lat = 0, lat_left = 0, hold_low = 0;
    int          stall_pct = 0, dmode = 0;
    bit          inj = 0;
    logic [15:0] rd_val = 16'd0;

    // observation stats
    int            n_strobe, clr_n, clr_last_edge, sp_bad, first_edge;
    logic [AW-1:0] clr_last_addr;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at edge %0d",
                     nm, act, exp, edge_n);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({mem_we, mem_rd, mem_addr, mem_din, cfg, busy, done});
    endfunction

    function automatic int last_clear(input logic [15:0] c);
        int full;
        full = c[2] ? 'h7FFFFFF : c[1] ? 'h3FFFFFF :
               c[0] ? 'h1FFFFFF : 'h0FFFFFF;
        return full & ((1 << AW) - 1);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_iss = 0; m_pace_at = 0; m_ca = 0;
        m_out = 0; m_we = 0; m_rd = 0;
        m_cfg = '0; m_din = '0; m_addr = '0;
        lat_left = 0; hold_low = 0;
    endtask

    task automatic clear_stats();
        n_strobe = 0; clr_n = 0; clr_last_edge = 0;
        sp_bad = 0; first_edge = -1; clr_last_addr = '0;
    endtask

    // what must happen at this rising edge given the inputs it saw
    task automatic model_edge();
        m_we = 0;
        m_rd = 0;
        if (!reset_n) begin
            model_reset();
        end else if (start && (m_mode == 0 || m_mode == 3)) begin
            m_mode = 1; m_k = 0; m_cfg = '0; m_out = 0;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (m_out) begin
                if (edge_n >= m_iss + 2 && mem_ready) begin
                    m_out = 0;
                    if (m_mode == 1) begin
                        if (!t_wr[m_k])
                            m_cfg[t_bit[m_k]] = mem_dout == t_data[m_k];
                        if (m_k == 6) begin
                            m_cfg[15] = 1'b1;
                            m_mode = 2; m_ca = 0;
                            m_pace_at = edge_n + PC;
                        end else begin
                            m_k++;
                        end
                    end else if (m_ca == last_clear(m_cfg)) begin
                        m_mode = 3;
                    end else begin
                        m_ca++;
                    end
                end
            end else if (mem_ready &&
                         (m_mode == 1 || edge_n >= m_pace_at)) begin
                m_out = 1;
                m_iss = edge_n;
                if (m_mode == 1) begin
                    m_addr = AW'(t_addr[m_k]);
                    if (t_wr[m_k]) begin
                        m_we = 1; m_din = t_data[m_k];
                    end else begin
                        m_rd = 1;
                    end
                end else begin
                    m_we = 1; m_addr = AW'(m_ca); m_din = '0;
                    m_pace_at = edge_n + PC;
                end
            end
        end
    endtask

    task automatic respond();
        start = 1'b0;
        if (m_rd) begin
            case (dmode)
                0: rd_val = t_data[m_k];
                1: rd_val = (m_k == 5) ? 16'd1032 : t_data[m_k];
                default: rd_val = $urandom_range(0, 1) != 0 ?
                                  t_data[m_k] : 16'($urandom);
            endcase
        end
        if (m_we || m_rd) lat_left = lat;
        if (hold_low > 0) begin
            mem_ready = 1'b0; hold_low--;
        end else if (lat_left > 0) begin
            mem_ready = 1'b0; lat_left--;
        end else begin
            mem_ready = $urandom_range(0, 99) >= stall_pct;
        end
        mem_dout = mem_ready ? rd_val : 16'($urandom);
        if (inj && (m_mode == 1 || m_mode == 2) &&
            $urandom_range(0, 149) == 0)
            start = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk_sys);
        edge_n++;
        model_edge();
        chk("cycle", outs(), 64'({m_we, m_rd, m_addr, m_din, m_cfg,
            m_mode == 1 || m_mode == 2, m_mode == 3}));
        if (mem_we || mem_rd) begin
            n_strobe++;
            if (first_edge < 0) first_edge = edge_n;
        end
        if (mem_we && busy && mem_din == 16'd0) begin
            if (clr_n > 0 && edge_n - clr_last_edge != PC) sp_bad++;
            clr_n++;
            clr_last_edge = edge_n;
            clr_last_addr = mem_addr;
        end
        respond();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
    endtask

    task automatic run_to_done(input string nm);
        int n = 0;
        while (!(done === 1'b1 && m_mode == 3) && n < 20000) begin
            cyc();
            n++;
        end
        chk({nm, "_finish"}, 64'(n < 20000), 64'd1);
    endtask

    initial begin
        int n, s_edge;
        model_reset();
        clear_stats();
        repeat (3) cyc();
        chk("reset_state", outs(), 64'd0);
        reset_n = 1'b1;
        clear_stats();
        repeat (10) cyc();
        chk("idle_quiet", 64'(n_strobe), 64'd0);

        lat = 3; stall_pct = 0; dmode = 0; inj = 0;
        clear_stats();
        pulse_start();
        run_to_done("ideal");
        chk("ideal_cfg", 64'(cfg), 64'h8007);
        chk("ideal_nclr", 64'(clr_n), 64'd256);
        chk("ideal_last", 64'(clr_last_addr), 64'hFF);
        clear_stats();
        repeat (20) cyc();
        chk("done_quiet1", 64'(n_strobe), 64'd0);

        lat = 0; dmode = 1;
        clear_stats();
        pulse_start();
        chk("restart_cfg", 64'(cfg), 64'd0);
        run_to_done("alias");
        chk("alias_cfg", 64'(cfg), 64'h8005);
        chk("alias_pace", 64'(sp_bad), 64'd0);
        chk("alias_nclr", 64'(clr_n), 64'd256);
        chk("alias_last", 64'(clr_last_addr), 64'hFF);

        lat = 1; dmode = 2;
        clear_stats();
        mem_ready = 1'b0;
        hold_low = 99;
        pulse_start();
        s_edge = edge_n;
        n = 0;
        while (first_edge < 0 && n < 500) begin cyc(); n++; end
        chk("stall_delay", 64'(first_edge - s_edge), 64'd100);
        stall_pct = 20; inj = 1;
        n = 0;
        while (clr_n < 3 && n < 5000) begin cyc(); n++; end
        chk("reach_clr3", 64'(clr_n), 64'd3);
        reset_n = 1'b0;
        #1;
        chk("async_abort", outs(), 64'd0);
        inj = 0; stall_pct = 0;
        repeat (2) cyc();
        reset_n = 1'b1;
        clear_stats();
        repeat (30) cyc();
        chk("post_reset_quiet", 64'(n_strobe), 64'd0);

        stall_pct = 30; lat = 2; dmode = 2; inj = 1;
        clear_stats();
        pulse_start();
        run_to_done("random");
        inj = 0; stall_pct = 0;
        clear_stats();
        repeat (20) cyc();
        chk("done_quiet2", 64'(n_strobe), 64'd0);
        chk("done_flags", 64'({done, busy}), 64'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
